// File: rtl/id_ex_stage.sv
//------------------------------------------------------------------------------
// Module      : id_ex_stage
// Description : ID/EX pipeline register for the RV64 5-stage pipeline, with
//               load-use hazard detection, flush and freeze. Optional
//               load-use stall counter enabled by macro ID_EX_STALL_CNT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic              id_reg_write,
   input  logic              id_mem_to_reg,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_branch,
   input  logic              id_alu_src,
   input  logic [1:0]        id_alu_op,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [2:0]        id_funct3,
   input  logic              id_funct7b5,
   input  logic              flush,
   input  logic              freeze,
`ifdef ID_EX_STALL_CNT_EN
   output logic [31:0]       stall_cnt,
`endif
   output logic              pc_write,
   output logic              if_id_write,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_to_reg,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_branch,
   output logic              ex_alu_src,
   output logic [1:0]        ex_alu_op,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [2:0]        ex_funct3,
   output logic              ex_funct7b5
);

   logic              r_valid;
   logic              r_reg_write;
   logic              r_mem_to_reg;
   logic              r_mem_read;
   logic              r_mem_write;
   logic              r_branch;
   logic              r_alu_src;
   logic [1:0]        r_alu_op;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_rs1_data;
   logic [XLEN-1:0]   r_rs2_data;
   logic [XLEN-1:0]   r_imm;
   logic [REG_AW-1:0] r_rs1;
   logic [REG_AW-1:0] r_rs2;
   logic [REG_AW-1:0] r_rd;
   logic [2:0]        r_funct3;
   logic              r_funct7b5;

   logic w_load_use;
   logic w_bubble;

   // rs2 is compared regardless of opcode; a spurious stall behind ld is harmless.
   assign w_load_use = r_valid & r_mem_read & (r_rd != '0) & id_valid &
                       ((r_rd == id_rs1) | (r_rd == id_rs2));

   assign pc_write    = ~(w_load_use | freeze);
   assign if_id_write = ~(w_load_use | freeze);

   // Flush overrides freeze; a load-use bubble only applies when not frozen.
   assign w_bubble = reset | flush | (~freeze & w_load_use);

   always_ff @(posedge clk) begin
      if (w_bubble) begin
         r_valid      <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_branch     <= 1'b0;
         r_alu_src    <= 1'b0;
         r_alu_op     <= 2'b00;
         r_pc         <= '0;
         r_rs1_data   <= '0;
         r_rs2_data   <= '0;
         r_imm        <= '0;
         r_rs1        <= '0;
         r_rs2        <= '0;
         r_rd         <= '0;
         r_funct3     <= 3'b000;
         r_funct7b5   <= 1'b0;
      end else if (!freeze) begin
         r_valid      <= id_valid;
         r_reg_write  <= id_reg_write  & id_valid;
         r_mem_to_reg <= id_mem_to_reg & id_valid;
         r_mem_read   <= id_mem_read   & id_valid;
         r_mem_write  <= id_mem_write  & id_valid;
         r_branch     <= id_branch     & id_valid;
         r_alu_src    <= id_alu_src    & id_valid;
         r_alu_op     <= id_alu_op & {2{id_valid}};
         r_pc         <= id_pc;
         r_rs1_data   <= id_rs1_data;
         r_rs2_data   <= id_rs2_data;
         r_imm        <= id_imm;
         r_rs1        <= id_rs1;
         r_rs2        <= id_rs2;
         r_rd         <= id_rd;
         r_funct3     <= id_funct3;
         r_funct7b5   <= id_funct7b5;
      end
   end

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= 32'd0;
      end else if (!flush && !freeze && w_load_use) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

   assign ex_valid      = r_valid;
   assign ex_reg_write  = r_reg_write;
   assign ex_mem_to_reg = r_mem_to_reg;
   assign ex_mem_read   = r_mem_read;
   assign ex_mem_write  = r_mem_write;
   assign ex_branch     = r_branch;
   assign ex_alu_src    = r_alu_src;
   assign ex_alu_op     = r_alu_op;
   assign ex_pc         = r_pc;
   assign ex_rs1_data   = r_rs1_data;
   assign ex_rs2_data   = r_rs2_data;
   assign ex_imm        = r_imm;
   assign ex_rs1        = r_rs1;
   assign ex_rs2        = r_rs2;
   assign ex_rd         = r_rd;
   assign ex_funct3     = r_funct3;
   assign ex_funct7b5   = r_funct7b5;

endmodule

`default_nettype wire
